// File: rtl/riscv_wb_pkg.sv
// Shared writeback-stage definitions: source codes, default widths and the
// entry type carried through the MEM/WB register slice.
package riscv_wb_pkg;

    localparam int WB_XLEN  = 32;
    localparam int WB_N_SRC = 4;
    localparam int WB_RD_W  = 5;

    localparam int WB_SEL_ALU = 0;
    localparam int WB_SEL_MEM = 1;
    localparam int WB_SEL_PC4 = 2;
    localparam int WB_SEL_IMM = 3;

    typedef struct packed {
        logic [WB_XLEN-1:0] data;
        logic [WB_RD_W-1:0] rd;
        logic               we;
        logic               sel_err;
    } wb_entry_t;

endpackage

// File: rtl/wb_skid_buffer.sv
// Two-entry valid/ready register slice (main + skid) over an arbitrary packed
// entry type; in_ready is purely registered so out_ready never reaches it.
module wb_skid_buffer
    import riscv_wb_pkg::*;
#(
    parameter type entry_t = wb_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   in_valid,
    output logic   in_ready,
    input  entry_t in_entry,
    output logic   out_valid,
    input  logic   out_ready,
    output entry_t out_entry
);

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   accept;

    assign in_ready  = !skid_valid_q && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = main_valid_q;
    assign out_entry = main_q;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            // Payloads are left in place; only the valid bits matter here.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_ready) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                if (accept) begin
                    main_d = in_entry;
                end
                main_valid_d = accept;
            end
        end else if (accept) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

endmodule

// File: rtl/wb_select_stage.sv
// Writeback source select with x0 guard and illegal-code flag, registered
// into the MEM/WB boundary through a skid-buffered valid/ready slice.
module wb_select_stage
    import riscv_wb_pkg::*;
#(
    parameter int XLEN  = WB_XLEN,
    parameter int N_SRC = WB_N_SRC,
    parameter int SEL_W = $clog2(N_SRC),
    parameter int RD_W  = WB_RD_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_SRC*XLEN-1:0] in_src,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic [RD_W-1:0]       in_rd,
    input  logic                  in_we,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_data,
    output logic [RD_W-1:0]       out_rd,
    output logic                  out_we,
    output logic                  out_sel_err
);

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [RD_W-1:0] rd;
        logic            we;
        logic            sel_err;
    } entry_t;

    entry_t          sel_entry;
    entry_t          main_entry;
    logic            legal;
    logic [XLEN-1:0] picked;

    // Explicit compare per source keeps unused codes at a defined zero.
    always_comb begin
        picked = '0;
        legal  = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            if (in_sel == SEL_W'(k)) begin
                picked = in_src[k*XLEN +: XLEN];
                legal  = 1'b1;
            end
        end
        sel_entry.rd      = in_rd;
        sel_entry.sel_err = !legal;
        if (!legal || in_rd == '0) begin
            sel_entry.data = '0;
            sel_entry.we   = 1'b0;
        end else begin
            sel_entry.data = picked;
            sel_entry.we   = in_we;
        end
    end

    wb_skid_buffer #(
        .entry_t (entry_t)
    ) u_slice (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_entry  (sel_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_entry (main_entry)
    );

    assign out_data    = main_entry.data;
    assign out_rd      = main_entry.rd;
    assign out_we      = main_entry.we && out_valid;
    assign out_sel_err = main_entry.sel_err;

endmodule

// File: tb/tb_wb_select_stage.sv
// Scoreboard bench for wb_select_stage: a 4-source and a 3-source instance.
module tb_wb_select_stage;

    localparam int XLEN = 32;
    localparam int RD_W = 5;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [RD_W-1:0] rd;
        logic            we;
        logic            err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush;

    logic              in_valid, in_ready, in_we, out_valid, out_ready, out_we, out_sel_err;
    logic [4*XLEN-1:0] in_src;
    logic [1:0]        in_sel;
    logic [RD_W-1:0]   in_rd, out_rd;
    logic [XLEN-1:0]   out_data;

    logic              in_valid3, in_ready3, in_we3, out_valid3, out_ready3, out_we3, out_sel_err3;
    logic [3*XLEN-1:0] in_src3;
    logic [1:0]        in_sel3;
    logic [RD_W-1:0]   in_rd3, out_rd3;
    logic [XLEN-1:0]   out_data3;

    wb_select_stage #(.XLEN(XLEN), .N_SRC(4), .RD_W(RD_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_src(in_src), .in_sel(in_sel),
        .in_rd(in_rd), .in_we(in_we),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_we(out_we), .out_sel_err(out_sel_err)
    );

    wb_select_stage #(.XLEN(XLEN), .N_SRC(3), .RD_W(RD_W)) dut3 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_src(in_src3), .in_sel(in_sel3),
        .in_rd(in_rd3), .in_we(in_we3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .out_rd(out_rd3), .out_we(out_we3), .out_sel_err(out_sel_err3)
    );

    exp_t q[$];
    exp_t q3[$];
    int   pop_cyc[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   acc_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitors: pop one expectation per handshake on each instance
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out4 actual=%h required=none", out_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                pop_cyc.push_back(cyc);
                check("out4_data", out_data, e.data);
                check("out4_rd", XLEN'(out_rd), XLEN'(e.rd));
                check("out4_we", XLEN'(out_we), XLEN'(e.we));
                check("out4_err", XLEN'(out_sel_err), XLEN'(e.err));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid3 && out_ready3) begin
            if (q3.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out3 actual=%h required=none", out_data3);
            end else begin
                exp_t e;
                e = q3.pop_front();
                check("out3_data", out_data3, e.data);
                check("out3_rd", XLEN'(out_rd3), XLEN'(e.rd));
                check("out3_we", XLEN'(out_we3), XLEN'(e.we));
                check("out3_err", XLEN'(out_sel_err3), XLEN'(e.err));
            end
        end
    end

    task automatic push4(input logic [XLEN-1:0] s0, input logic [XLEN-1:0] s1,
                         input logic [XLEN-1:0] s2, input logic [XLEN-1:0] s3,
                         input logic [1:0] sel, input logic [RD_W-1:0] rd,
                         input logic we, input exp_t e);
        int n;
        in_src   = {s3, s2, s1, s0};
        in_sel   = sel;
        in_rd    = rd;
        in_we    = we;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept4_timeout actual=in_ready_low required=accept");
        end else begin
            q.push_back(e);
            acc_cyc = cyc;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic push3(input logic [XLEN-1:0] s2, input logic [1:0] sel,
                         input logic [RD_W-1:0] rd, input exp_t e);
        int n;
        in_src3   = {s2, 32'h0000_2222, 32'h0000_1111};
        in_sel3   = sel;
        in_rd3    = rd;
        in_we3    = 1'b1;
        in_valid3 = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready3) begin
            total++;
            bad++;
            $display("FAIL accept3_timeout actual=in_ready_low required=accept");
        end else begin
            q3.push_back(e);
        end
        @(posedge clk);
        #1 in_valid3 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_src = '0; in_sel = '0; in_rd = '0; in_we = 1'b0; out_ready = 1'b1;
        in_valid3 = 1'b0; in_src3 = '0; in_sel3 = '0; in_rd3 = '0; in_we3 = 1'b0; out_ready3 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("ready_in_rst", XLEN'(in_ready), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", XLEN'(out_valid), 0);
        check("rst_data", out_data, 0);
        check("rst_rd", XLEN'(out_rd), 0);
        check("rst_we", XLEN'(out_we), 0);
        check("rst_err", XLEN'(out_sel_err), 0);
        check("rst_ready", XLEN'(in_ready), 1);
        @(posedge clk);
        #1;

        // Basic selects, x0 guard
        push4(32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 2'd1, 5'd7, 1'b1, '{32'hDEADBEEF, 5'd7, 1'b1, 1'b0});
        push4(32'h1234, 32'hDEADBEEF, 32'h0, 32'h0, 2'd0, 5'd0, 1'b1, '{32'h0, 5'd0, 1'b0, 1'b0});
        push4(32'h1, 32'h2, 32'h0000_0104, 32'h4, 2'd2, 5'd3, 1'b0, '{32'h0000_0104, 5'd3, 1'b0, 1'b0});
        push4(32'h1, 32'h2, 32'h3, 32'hFFFF_F800, 2'd3, 5'd31, 1'b1, '{32'hFFFF_F800, 5'd31, 1'b1, 1'b0});
        idle(3);

        // Stall: A in main, B in skid
        out_ready = 1'b0;
        push4(32'hAAAA, 32'h0, 32'h0, 32'h0, 2'd0, 5'd1, 1'b1, '{32'hAAAA, 5'd1, 1'b1, 1'b0});
        push4(32'hBBBB, 32'h0, 32'h0, 32'h0, 2'd0, 5'd2, 1'b1, '{32'hBBBB, 5'd2, 1'b1, 1'b0});
        @(negedge clk);
        check("full_ready", XLEN'(in_ready), 0);
        check("stall_valid", XLEN'(out_valid), 1);
        check("stall_hold", out_data, 32'hAAAA);
        @(negedge clk);
        check("stall_hold2", out_data, 32'hAAAA);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("drain_ready0", XLEN'(in_ready), 0);
        @(negedge clk);
        check("drain_ready1", XLEN'(in_ready), 1);
        idle(3);
        check("drain_q_empty", XLEN'(q.size()), 0);

        // Back-to-back stream
        pop_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            int first;
            e = '{XLEN'(32'h10 + i), 5'd10, 1'b1, 1'b0};
            push4(32'h0, XLEN'(32'h10 + i), 32'h0, 32'h0, 2'd1, 5'd10, 1'b1, e);
            if (i == 0) first = acc_cyc;
            if (i == 7) begin
                repeat (4) @(negedge clk);
                check("stream_count", XLEN'(pop_cyc.size()), 8);
                if (pop_cyc.size() == 8) begin
                    check("stream_latency", XLEN'(pop_cyc[0]), XLEN'(first + 1));
                    for (int j = 1; j < 8; j++)
                        check("stream_gap", XLEN'(pop_cyc[j] - pop_cyc[j-1]), 1);
                end
            end
        end
        idle(2);

        // Flush mid-stall: C and D must never appear
        out_ready = 1'b0;
        push4(32'hCCCC, 32'h0, 32'h0, 32'h0, 2'd0, 5'd4, 1'b1, '{32'hCCCC, 5'd4, 1'b1, 1'b0});
        push4(32'hDDDD, 32'h0, 32'h0, 32'h0, 2'd0, 5'd5, 1'b1, '{32'hDDDD, 5'd5, 1'b1, 1'b0});
        @(negedge clk);
        check("flush_pre_ready", XLEN'(in_ready), 0);
        @(posedge clk);
        #1 flush = 1'b1;
        q.delete();
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_valid", XLEN'(out_valid), 0);
        check("flush_we", XLEN'(out_we), 0);
        check("flush_ready", XLEN'(in_ready), 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        idle(4);

        // Reset mid-stall: E and F must never appear
        out_ready = 1'b0;
        push4(32'hEEEE, 32'h0, 32'h0, 32'h0, 2'd0, 5'd6, 1'b1, '{32'hEEEE, 5'd6, 1'b1, 1'b0});
        push4(32'hFFFF, 32'h0, 32'h0, 32'h0, 2'd0, 5'd8, 1'b1, '{32'hFFFF, 5'd8, 1'b1, 1'b0});
        @(posedge clk);
        #1 rst = 1'b1;
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst2_valid", XLEN'(out_valid), 0);
        check("rst2_data", out_data, 0);
        check("rst2_ready", XLEN'(in_ready), 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        idle(4);

        // Three-source instance: code 3 is illegal
        push3(32'h0000_CAFE, 2'd3, 5'd5, '{32'h0, 5'd5, 1'b0, 1'b1});
        push3(32'h0000_CAFE, 2'd2, 5'd5, '{32'h0000_CAFE, 5'd5, 1'b1, 1'b0});
        push3(32'h0000_CAFE, 2'd3, 5'd0, '{32'h0, 5'd0, 1'b0, 1'b1});
        push3(32'h0000_CAFE, 2'd1, 5'd9, '{32'h0000_2222, 5'd9, 1'b1, 1'b0});
        idle(4);

        check("q4_empty", XLEN'(q.size()), 0);
        check("q3_empty", XLEN'(q3.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_select_stage.md
Name: wb_select_stage

Overview:
- Parametrised, registered successor to the single-cycle writeback-source mux, for the pipelined RV32I core.
- Selects one of N_SRC candidate writeback values (ALU result, load data, PC+4, immediate, ...) by a select code.
- Applies the x0 write guard and reports illegal select codes.
- Registers the result into a MEM/WB-boundary stage with a valid/ready handshake and a one-entry skid buffer, so back-pressure never loses an instruction.

Parameters:
- XLEN, 32, data width of each source and of the result.
- N_SRC, 4, number of writeback sources (must be ≥ 2).
- SEL_W, $clog2(N_SRC), select width (derived; do not override).
- RD_W, 5, destination register index width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline flush; discards both entries.
- in_valid  input  1  upstream holds a valid instruction.
- in_ready  output  1  stage can accept this cycle.
- in_src  input  N_SRC*XLEN  flattened sources; source k occupies bits [k*XLEN +: XLEN].
- in_sel  input  SEL_W  writeback source index.
- in_rd  input  RD_W  destination register.
- in_we  input  1  register-write enable.
- out_valid  output  1  registered result valid.
- out_ready  input  1  register file / downstream accepts.
- out_data  output  XLEN  selected value.
- out_rd  output  RD_W  destination register.
- out_we  output  1  effective write enable.
- out_sel_err  output  1  the instruction carried an illegal in_sel.

Interface: one clock; reset is synchronous and active-high (ports clk, rst).

Behaviour:
- Select (combinational, before the register):
  - If in_sel < N_SRC, data = source[in_sel].
  - If in_sel ≥ N_SRC (only possible when N_SRC is not a power of 2), data = 0, effective we = 0 and sel_err = 1. Never X.
- x0 guard: if in_rd == 0, effective we = 0 and data = 0. sel_err is unaffected by the guard.
- Storage: a main register (drives out_*) and a skid register, each holding {data, rd, we, sel_err, valid}.
- in_ready = !skid_valid && !rst. The state is a registered flag; there is no combinational path from out_ready.
- Accept when in_valid && in_ready.
- Per clock edge, in priority order:
  1. rst: out_valid = 0, skid_valid = 0, out_data = 0, out_rd = 0, out_we = 0, out_sel_err = 0. After reset, in_ready = 1.
  2. flush: same as rst for the valid bits and out_we. Data fields may hold their values. Any accept in that cycle is dropped.
  3. Main empty or out_ready high:
     - If skid_valid: main <= skid; skid_valid <= 0.
     - Else: main <= input and out_valid <= accept.
  4. Main full and out_ready low: if accept, skid <= input and skid_valid <= 1. Main holds.
- Latency: 1 cycle from accept to out_valid when unstalled. Throughput: 1 per cycle.
- out_* must stay stable while out_valid && !out_ready.
- Ordering is strict FIFO. No instruction is duplicated or dropped except by rst or flush.
- Boundary conditions:
  - Both entries full: in_ready = 0. A later out_ready=1 moves skid to main, and in_ready returns to 1 on the following cycle.
  - Simultaneous accept with out_ready=1 and skid empty: main is replaced in the same edge (pass-through).
  - rst or flush mid-stall: both entries are cleared, so nothing is emitted afterwards.
  - N_SRC = 2: SEL_W = 1 and every code is legal.

Decomposition:
- Package riscv_wb_pkg holds:
  - WB_SEL_ALU = 0, WB_SEL_MEM = 1, WB_SEL_PC4 = 2, WB_SEL_IMM = 3.
  - Default N_SRC and XLEN.
  - A packed wb_entry_t {data, rd, we, sel_err}.
- Sub-module wb_skid_buffer: generic 2-entry valid/ready register slice over wb_entry_t. It is instantiated once after the select/guard logic.

Test Plan:
- Reset, then sel=1, src1=0xDEADBEEF, rd=7, we=1, out_ready=1 -> next cycle out_valid=1, out_data=0xDEADBEEF, out_rd=7, out_we=1.
- Same stimulus with rd=0 and src0=0x1234 -> out_data=0, out_we=0, out_sel_err=0.
- N_SRC=3, sel=3 -> out_data=0, out_we=0, out_sel_err=1.
- out_ready=0 while pushing A, then B -> in_ready=0 after B. Raise out_ready -> A then B on consecutive cycles; no loss and no duplicate.
- Back-to-back stream of 8 values (0x10..0x17) with out_ready=1 -> 8 outputs on 8 consecutive cycles, in order, after 1-cycle latency.
- Stall with both entries full, assert flush (or rst) for one cycle -> out_valid=0, in_ready=1 next cycle, and neither stalled value ever appears.
